tdm_demux8: RTL
===============

Name: tdm_demux8

Overview:
- Registered 1-to-8 demultiplexer; the receive-side counterpart of the team's 8:1 select mux.
- Takes one sample stream and steers each accepted sample into one of 8 held output lanes.
- Two steering modes:
  - Explicit: a 3-bit select chooses the lane.
  - TDM: round-robin channel counter, aligned by a frame-sync marker.
- Sits after a serialiser/mux link; presents per-lane strobes so downstream logic knows which lane was refreshed.

Parameters:
- WIDTH, 1, bit width of each sample and of each output lane.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- din  input  WIDTH  sample to route
- din_valid  input  1  sample on din is accepted this cycle
- frame_sync  input  1  qualified by din_valid; marks din as channel-0 sample (TDM mode)
- mode  input  1  0 = explicit select, 1 = TDM round-robin
- sel  input  3  lane index in explicit mode; ignored in TDM mode
- dout  output  8*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]; registered
- dout_strobe  output  8  one-hot pulse, bit k high for one cycle after lane k is written
- frame_done  output  1  one-cycle pulse after the lane-7 write in TDM mode
- sync_err  output  1  one-cycle pulse when frame_sync arrives with the counter not at 0
- locked  output  1  high while the TDM FSM is in LOCK
- cur_ch  output  3  next lane the TDM counter will write

Behaviour:
- Reset (async assert, sync release), all outputs 0:
  - dout, dout_strobe, frame_done, sync_err, locked, cur_ch all 0.
  - FSM in HUNT.
- Latency: a sample accepted at edge N appears on dout lane and strobe after edge N (visible in cycle N+1). Lane holds its value until rewritten.
- No accept when din_valid=0:
  - dout unchanged.
  - dout_strobe, frame_done, sync_err = 0.
  - Counter and FSM unchanged.
- Explicit mode (mode=0):
  - Each valid sample is written to lane sel.
  - dout_strobe = 1<<sel.
  - FSM forced to HUNT; cur_ch held at 0; locked=0; frame_done and sync_err never assert.
- TDM FSM, states HUNT and LOCK (mode=1):
  - HUNT: valid samples without frame_sync are discarded (no lane write, no strobe). A valid sample with frame_sync is written to lane 0, cur_ch becomes 1, state goes to LOCK.
  - LOCK, normal: each valid sample is written to lane cur_ch, then cur_ch increments modulo 8.
  - LOCK, lane-7 write: cur_ch wraps to 0 and frame_done pulses with the lane-7 strobe.
  - LOCK, frame_sync with cur_ch=0: normal write to lane 0, no error.
  - LOCK, frame_sync with cur_ch!=0 (re-align): sample is written to lane 0, cur_ch becomes 1, sync_err pulses, frame_done does not pulse, state stays LOCK.
  - locked = (state == LOCK).
- Mode change: a mode 1→0 transition takes effect on the same accepted sample and drops the FSM to HUNT. A 0→1 transition starts in HUNT.
- Strobes never assert for discarded samples. At most one dout_strobe bit is high in any cycle.
- Mid-operation reset clears lane contents and lock immediately (asynchronously); the next frame needs a fresh frame_sync.

Optional Feature:
- Macro: TDM_DEMUX8_CLEAR_EN.
- Defined: every lane write also zeroes all other lanes in the same cycle, so dout shows only the most recent sample (true demux semantics). Applies in both modes.
- Undefined (default): unwritten lanes hold their last value.
- Strobe, frame_done and sync_err behaviour is identical in both builds.

Test Plan:
- Explicit routing, WIDTH=1:
  - Stimulus: mode=0, din=1 with sel=0..7 in consecutive valid cycles.
  - Response: dout goes 0x01, 0x03, … 0xFF; strobe walks 0x01→0x80; frame_done=0.
- TDM lock, WIDTH=8:
  - Stimulus: mode=1; two valid samples without sync, then frame_sync with din=0xA0, then 0xA1..0xA7.
  - Response: first two samples discarded with no strobe; lanes 0..7 = 0xA0..0xA7; locked=1 from the sync write; frame_done pulses once after the 0xA7 write; cur_ch=0.
- Valid gaps:
  - Stimulus: locked TDM stream with din_valid low for 3 cycles between channel 3 and channel 4.
  - Response: cur_ch stays at 4; no strobes during the gap; data lands in the correct lanes.
- Misaligned sync:
  - Stimulus: locked; after the channel-2 write, frame_sync with din=0x55.
  - Response: lane0=0x55, sync_err pulse, cur_ch=1, locked stays 1, no frame_done.
- Reset mid-frame:
  - Stimulus: assert rst between clock edges at cur_ch=5.
  - Response: all outputs 0 immediately; after release, samples are discarded until the next frame_sync.
- CLEAR_EN build:
  - Stimulus: mode=0, write 1 to sel=2, then to sel=6.
  - Response: dout=0x04, then 0x40 (lane 2 cleared). Default build gives 0x44.

Source files
------------

// File: rtl/tdm_demux8_if.sv
// rtl/tdm_demux8_if.sv - sample stream in, held lanes and status out, for tdm_demux8
// master drives the sample stream; slave is the demux.
interface tdm_demux8_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]   din;
  logic               din_valid;
  logic               frame_sync;
  logic               mode;
  logic [2:0]         sel;
  logic [8*WIDTH-1:0] dout;
  logic [7:0]         dout_strobe;
  logic               frame_done;
  logic               sync_err;
  logic               locked;
  logic [2:0]         cur_ch;

  modport master (
    output din, din_valid, frame_sync, mode, sel,
    input  dout, dout_strobe, frame_done, sync_err, locked, cur_ch
  );

  modport slave (
    input  din, din_valid, frame_sync, mode, sel,
    output dout, dout_strobe, frame_done, sync_err, locked, cur_ch
  );
endinterface

// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - registered 1:8 demux, explicit select or frame-synced TDM round-robin
// Optional build macro TDM_DEMUX8_CLEAR_EN: each lane write zeroes all other lanes.
module tdm_demux8 #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux8_if.slave  bus
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cur_ch_q, cur_ch_d;
  logic [8*WIDTH-1:0] dout_q, dout_d;
  logic [7:0]         strobe_q, strobe_d;
  logic               frame_done_q, frame_done_d;
  logic               sync_err_q, sync_err_d;

  logic               wr_en;
  logic [2:0]         wr_lane;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      cur_ch_q     <= 3'd0;
      dout_q       <= '0;
      strobe_q     <= 8'd0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_ch_q     <= cur_ch_d;
      dout_q       <= dout_d;
      strobe_q     <= strobe_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Steering decision: which lane (if any) this sample goes to, and FSM/counter update.
  always_comb begin
    state_d      = state_q;
    cur_ch_d     = cur_ch_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    wr_en        = 1'b0;
    wr_lane      = 3'd0;

    if (bus.din_valid) begin
      if (!bus.mode) begin
        wr_en    = 1'b1;
        wr_lane  = bus.sel;
        state_d  = HUNT;
        cur_ch_d = 3'd0;
      end else begin
        case (state_q)
          HUNT: begin
            if (bus.frame_sync) begin
              wr_en    = 1'b1;
              wr_lane  = 3'd0;
              cur_ch_d = 3'd1;
              state_d  = LOCK;
            end
          end
          LOCK: begin
            wr_en = 1'b1;
            if (bus.frame_sync && (cur_ch_q != 3'd0)) begin
              wr_lane    = 3'd0;
              cur_ch_d   = 3'd1;
              sync_err_d = 1'b1;
            end else begin
              wr_lane      = cur_ch_q;
              cur_ch_d     = cur_ch_q + 3'd1;
              frame_done_d = (cur_ch_q == 3'd7);
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  always_comb begin
    dout_d   = dout_q;
    strobe_d = 8'd0;
    if (wr_en) begin
`ifdef TDM_DEMUX8_CLEAR_EN
      dout_d = '0;
`endif
      dout_d[int'(wr_lane)*WIDTH +: WIDTH] = bus.din;
      strobe_d = 8'd1 << wr_lane;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.dout_strobe = strobe_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.locked      = (state_q == LOCK);
  assign bus.cur_ch      = cur_ch_q;

endmodule
